// File: rtl/iter_divider.sv
// iter_divider
//   Multi-cycle signed integer divider using the restoring (trial subtraction)
//   algorithm. One quotient bit is resolved per clock, MSB first. Operands are
//   converted to magnitudes on acceptance and the signs are reapplied when the
//   result is registered.
//
// Ports
//   clock       in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   start       in   1      request a division; only honoured while idle
//   dividend    in   WIDTH  signed dividend, captured on an accepted start
//   divisor     in   WIDTH  signed divisor, captured on an accepted start
//   busy        out  1      high while an operation is in flight
//   result_rdy  out  1      one-cycle pulse marking a valid result
//   quotient    out  WIDTH  signed quotient, truncated toward zero
//   remainder   out  WIDTH  signed remainder, sign follows the dividend
//   div_zero    out  1      divisor was zero for the reported result
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // r_quo starts out holding |dividend| and fills with quotient bits from the
  // bottom as dividend bits are shifted out of the top.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_count;
  logic             r_dvdNeg;
  logic             r_dvsNeg;
  logic             r_zero;

  logic             r_rdy;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divZero;

  logic [WIDTH-1:0] w_dvdAbs;
  logic [WIDTH-1:0] w_dvsAbs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Magnitudes wrap for the most-negative value, which is still the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign w_dvdAbs = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvsAbs = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The stored partial remainder is always below |divisor|, so WIDTH bits hold
  // it; the shifted trial value needs the extra bit so the subtraction's sign
  // bit (w_diff[WIDTH]) tells us whether the trial succeeded.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a zero divisor skips straight to reporting.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_count == LAST_ITER) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Iteration datapath: capture operands on accept, then one restoring step
  // per CALC cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_count  <= '0;
      r_dvdNeg <= 1'b0;
      r_dvsNeg <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_quo    <= w_dvdAbs;
            r_rem    <= '0;
            r_dvsr   <= w_dvsAbs;
            r_count  <= '0;
            r_dvdNeg <= dividend[WIDTH-1];
            r_dvsNeg <= divisor[WIDTH-1];
            r_zero   <= (divisor == '0);
          end
        end
        CALC: begin
          r_quo   <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          r_rem   <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_count <= r_count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated only in DONE and held until the next result.
  // On the zero-divide path r_quo still holds |dividend|, so re-signing it
  // recovers the original dividend for the remainder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divZero   <= 1'b0;
    end else begin
      r_rdy <= (r_state == DONE);
      if (r_state == DONE) begin
        if (r_zero) begin
          r_quotient  <= '0;
          r_remainder <= r_dvdNeg ? -r_quo : r_quo;
          r_divZero   <= 1'b1;
        end else begin
          r_quotient  <= (r_dvdNeg ^ r_dvsNeg) ? -r_quo : r_quo;
          r_remainder <= r_dvdNeg ? -r_rem : r_rem;
          r_divZero   <= 1'b0;
        end
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign result_rdy = r_rdy;
  assign quotient   = r_quotient;
  assign remainder  = r_remainder;
  assign div_zero   = r_divZero;

endmodule
